// File: rtl/flash_adc_pkg.sv
// Shared definitions for the flash ADC thermometer encoder pipeline:
// thermometer width helper, 3-input majority vote, averaging limit and
// the per-sample flag bundle.
package flash_adc_pkg;

  // Largest supported log2 of the averaging window.
  localparam int AVG_LOG2_MAX = 4;

  // Per-sample status carried alongside the encoded code.
  typedef struct packed {
    logic ovr;
    logic udr;
    logic bubble;
  } adc_flags_t;

  // Number of comparators needed for a bits-wide output code.
  function automatic int therm_width(input int bits);
    return (1 << bits) - 1;
  endfunction

  // 2-of-3 majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/flash_adc_bubble_fix.sv
// Combinational majority-vote bubble correction for an N-bit thermometer
// code. The word is padded with a virtual 1 below bit 0 and a virtual 0
// above bit N-1, so a clean code passes through unchanged and isolated
// errors at either end are still voted out.
module flash_adc_bubble_fix
  import flash_adc_pkg::*;
#(
  parameter int N = 255
) (
  input  logic [N-1:0] therm,
  output logic [N-1:0] clean,
  output logic         bubble
);

  logic [N+1:0] ext_s;

  assign ext_s = {1'b0, therm, 1'b1};

  // Vote each comparator with its two neighbours; flag any corrected bit.
  always_comb begin
    clean = '0;
    for (int i = 0; i < N; i++) begin
      clean[i] = maj3(ext_s[i], ext_s[i+1], ext_s[i+2]);
    end
    bubble = |(clean ^ therm);
  end

endmodule

// File: rtl/flash_adc_encoder_pipe.sv
// Flash ADC back end: 3-stage valid-qualified thermometer-to-binary encoder
// with bubble correction, range flags, optional 2**AVG_LOG2 averaging
// (AVG_LOG2 must stay within 0..AVG_LOG2_MAX) and a bubble-event counter.
// Optional feature macro: BUBBLE_CNT_EN enables the saturating bubble
// counter; without it bubble_cnt reads 0 and clr_cnt is ignored.
module flash_adc_encoder_pipe
  import flash_adc_pkg::*;
#(
  parameter int BITS     = 8,
  parameter int AVG_LOG2 = 0,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_vld,
  input  logic [therm_width(BITS)-1:0] therm_in,
  input  logic                         clr_cnt,
  output logic [BITS-1:0]              code_out,
  output logic                         code_vld,
  output logic                         ovr,
  output logic                         udr,
  output logic [CNT_W-1:0]             bubble_cnt
);

  localparam int N = therm_width(BITS);

  logic             s1_vld_r;
  logic [N-1:0]     s1_therm_r;
  logic [N-1:0]     clean_s;
  logic             bubble_s;
  logic             s2_vld_r;
  logic             s2_bub_r;
  logic [N-1:0]     s2_clean_r;
  logic [BITS-1:0]  code_s;
  logic             s3_vld_r;
  logic [BITS-1:0]  s3_code_r;
  adc_flags_t       s3_flags_r;

  // S1: capture the comparator bank and its valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_r   <= 1'b0;
      s1_therm_r <= '0;
    end else begin
      s1_vld_r   <= sample_vld;
      s1_therm_r <= therm_in;
    end
  end

  flash_adc_bubble_fix #(.N(N)) u_bubble_fix (
    .therm  (s1_therm_r),
    .clean  (clean_s),
    .bubble (bubble_s)
  );

  // S2: register the corrected code; bubble only counts on a valid sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld_r   <= 1'b0;
      s2_bub_r   <= 1'b0;
      s2_clean_r <= '0;
    end else begin
      s2_vld_r   <= s1_vld_r;
      s2_bub_r   <= bubble_s & s1_vld_r;
      s2_clean_r <= clean_s;
    end
  end

  // Encoder: code is one above the highest set comparator, 0 if none.
  always_comb begin
    code_s = '0;
    for (int i = 0; i < N; i++) begin
      code_s = s2_clean_r[i] ? BITS'(i + 1) : code_s;
    end
  end

  // S3: register code and flags on valid samples only, so they hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_vld_r   <= 1'b0;
      s3_code_r  <= '0;
      s3_flags_r <= '0;
    end else begin
      s3_vld_r <= s2_vld_r;
      if (s2_vld_r) begin
        s3_code_r         <= code_s;
        s3_flags_r.ovr    <= &s2_clean_r;
        s3_flags_r.udr    <= ~|s2_clean_r;
        s3_flags_r.bubble <= s2_bub_r;
      end else begin
        s3_code_r  <= s3_code_r;
        s3_flags_r <= s3_flags_r;
      end
    end
  end

  generate
    if (AVG_LOG2 == 0) begin : g_direct
      assign code_out = s3_code_r;
      assign code_vld = s3_vld_r;
      assign ovr      = s3_flags_r.ovr;
      assign udr      = s3_flags_r.udr;
    end else begin : g_avg
      localparam int SW = BITS + AVG_LOG2;
      localparam logic [SW-1:0] HALF = {{(SW-1){1'b0}}, 1'b1} << (AVG_LOG2 - 1);

      logic [SW-1:0]       acc_r;
      logic [SW-1:0]       sum_s;
      logic [SW-1:0]       rnd_s;
      logic [AVG_LOG2-1:0] win_cnt_r;
      logic                win_ovr_r;
      logic                win_udr_r;
      logic [BITS-1:0]     code_r;
      logic                vld_r;
      logic                ovr_r;
      logic                udr_r;
      logic                unused_rnd_s;

      // Sum including the current code; it cannot overflow SW bits even
      // with the rounding half added.
      assign sum_s        = acc_r + SW'(s3_code_r);
      assign rnd_s        = sum_s + HALF;
      assign unused_rnd_s = ^rnd_s[AVG_LOG2-1:0];

      // Averager: accumulate valid codes, emit rounded mean on window end.
      always_ff @(posedge clk) begin
        if (rst) begin
          acc_r     <= '0;
          win_cnt_r <= '0;
          win_ovr_r <= 1'b0;
          win_udr_r <= 1'b0;
          code_r    <= '0;
          vld_r     <= 1'b0;
          ovr_r     <= 1'b0;
          udr_r     <= 1'b0;
        end else begin
          vld_r <= 1'b0;
          if (s3_vld_r) begin
            if (win_cnt_r == '1) begin
              code_r    <= rnd_s[SW-1:AVG_LOG2];
              ovr_r     <= win_ovr_r | s3_flags_r.ovr;
              udr_r     <= win_udr_r | s3_flags_r.udr;
              vld_r     <= 1'b1;
              acc_r     <= '0;
              win_cnt_r <= '0;
              win_ovr_r <= 1'b0;
              win_udr_r <= 1'b0;
            end else begin
              acc_r     <= sum_s;
              win_cnt_r <= win_cnt_r + AVG_LOG2'(1);
              win_ovr_r <= win_ovr_r | s3_flags_r.ovr;
              win_udr_r <= win_udr_r | s3_flags_r.udr;
            end
          end else begin
            acc_r <= acc_r;
          end
        end
      end

      assign code_out = code_r;
      assign code_vld = vld_r;
      assign ovr      = ovr_r;
      assign udr      = udr_r;
    end
  endgenerate

`ifdef BUBBLE_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_r;

  // Bubble counter: clear wins over increment; saturate at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr_cnt) begin
      cnt_r <= '0;
    end else if (s3_vld_r && s3_flags_r.bubble && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign bubble_cnt = cnt_r;
`else
  logic unused_cnt_s;

  assign unused_cnt_s = clr_cnt ^ s3_flags_r.bubble;
  assign bubble_cnt   = '0;
`endif

endmodule

// File: doc/flash_adc_encoder_pipe.md
Name: flash_adc_encoder_pipe

Overview:
- Parametrised next-generation thermometer-to-binary encoder for the flash ADC back end.
- Resolution is set by BITS. Adds a valid-qualified 3-stage pipeline, majority-vote bubble correction with bubble detection, over/under-range flags, optional power-of-two averaging/decimation, and a saturating bubble-event counter.
- Sits between the comparator bank capture and the downstream sample sink.

Parameters:
- BITS, 8, output code width; thermometer width N = 2**BITS-1 (derived localparam, not overridable).
- AVG_LOG2, 0, log2 of samples averaged per output; legal range 0..4; 0 = no averaging.
- CNT_W, 16, bubble counter width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- sample_vld  in  1  therm_in valid this cycle.
- therm_in  in  N  raw thermometer code; bit 0 = lowest comparator.
- clr_cnt  in  1  synchronous clear of bubble_cnt.
- code_out  out  BITS  encoded (averaged) code.
- code_vld  out  1  single-cycle strobe, code_out valid.
- ovr  out  1  over-range flag, qualified by code_vld.
- udr  out  1  under-range flag, qualified by code_vld.
- bubble_cnt  out  CNT_W  saturating count of samples containing bubbles.

Behaviour:
- Reset: code_out=0, code_vld=0, ovr=0, udr=0, bubble_cnt=0; all pipeline valids, the accumulator and the sample counter are cleared. Reset mid-window discards the partial window.
- S1: register therm_in and sample_vld. No stall and no backpressure; the valid bit travels with data every cycle.
- S2, majority correction: clean[i] = maj(t[i-1], t[i], t[i+1]), with t[-1]=1 and t[N]=0.
  - bubble = (clean != t) on a valid sample.
  - Register clean, bubble and valid.
- S3, encoding: code = (index of highest 1 in clean)+1, or 0 if clean is all zero.
  - o = (clean all ones); u = (clean all zero).
  - Register code, o, u and valid.
- AVG_LOG2=0: S3 drives the outputs directly. code_vld asserts exactly 3 cycles after sample_vld.
- AVG_LOG2=A>0: accumulate 2**A valid S3 codes into a BITS+A-bit sum.
  - On the last sample of the window, code_out = (sum + 2**(A-1)) >> A, i.e. round half up. No saturation is needed because the result is provably at most 2**BITS-1.
  - ovr and udr are the OR of o and u over the window.
  - code_vld pulses one cycle later than S3, so latency is 4 cycles from the final sample of the window.
  - The accumulator restarts at 0 in the same cycle. Invalid cycles do not advance the window.
- code_out, ovr and udr hold their values between strobes.
- bubble_cnt:
  - Increments by 1 per valid sample with bubble=1.
  - Saturates at 2**CNT_W-1.
  - clr_cnt has priority over a simultaneous increment, and the result is 0.
- Back-to-back samples: full throughput, one sample per cycle.

Optional Feature:
- BUBBLE_CNT_EN defined: bubble_cnt behaves as specified above.
- BUBBLE_CNT_EN not defined: the counter logic is removed, bubble_cnt is tied to 0 and clr_cnt is ignored. Correction and encoding are unchanged.

Decomposition:
- Shared package flash_adc_pkg:
  - function therm_width(bits) returning 2**bits-1.
  - function maj3.
  - constant AVG_LOG2_MAX=4.
  - typedef for the flag bundle {ovr, udr, bubble}.
- One sub-module, flash_adc_bubble_fix. It is combinational N-bit majority correction with a bubble-detect output, instantiated in S2.
- Pipeline registers, encoder, averager and counter stay in the top.

Test Plan:
- BITS=8, A=0: therm_in=0x0..0_FFFF (16 ones) with sample_vld for 1 cycle -> code_vld 3 cycles later, code_out=16, ovr=0, udr=0, bubble_cnt=0.
- Bubbles: ones in bits 0..39 with bit 20 cleared -> code_out=40 and bubble_cnt=1. Next, bits 0..39 plus isolated bit 100 -> code_out=40, bubble_cnt=2.
- Range: all-ones -> code_out=255, ovr=1. All-zero -> code_out=0, udr=1. Continuous 1/cycle stream of 10 samples -> 10 consecutive code_vld pulses in order.
- A=2: valid codes 10, 11, 11, 12 with sample_vld gaps between them -> one code_vld, code_out=11 (44+2=46, >>2). Codes 0, 0, 0, 1 -> code_out=0, udr=1.
- Reset mid-window (A=2): 2 samples of 100, then rst for 1 cycle, then 4 samples of 50 -> single strobe, code_out=50, no output from the partial window.
- Counter (macro defined, CNT_W=4): 20 bubbled samples -> bubble_cnt=15. clr_cnt coincident with a bubbled sample -> 0. Build without the macro -> bubble_cnt stays 0.
